// File: rtl/queue.sv
// queue: byte-wide circular FIFO with QS entries.
//
// The producer does not use a write enable. Every change of pWR from the value
// sampled on the previous edge counts as one write, and the data is stored at
// address pWR. The consumer pops the oldest byte onto out_queue by holding
// query high for one edge.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active high
//   pWR        producer write pointer (PW bits)
//   in_data    write data, sampled together with pWR
//   query      read request, level-sampled on every edge
//   out_queue  registered read data; holds until the next successful read
//   qcount     number of stored entries, 0..QS
//   full       flow control; also rises one cycle early when a write lands at QS-1
module queue #(
    parameter int QS = 8,
    localparam int PW = $clog2(QS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [PW-1:0] pWR,
    input  logic [7:0]    in_data,
    input  logic          query,
    output logic [7:0]    out_queue,
    output logic [7:0]    qcount,
    output logic          full
);

    localparam logic [7:0] QS_CNT = 8'(QS);

    logic [7:0]    mem [QS];
    logic [PW-1:0] prev_ptr_q, prev_ptr_d;
    logic [PW-1:0] rd_ptr_q,   rd_ptr_d;
    logic [7:0]    qcount_q,   qcount_d;
    logic [7:0]    out_q,      out_d;
    logic          wr, wr_acc, rd;

    always_comb begin
        wr         = (pWR != prev_ptr_q);
        // The write is judged against the count before this edge's read, so a
        // write arriving while the queue is full is dropped even if a pop
        // happens on the same edge.
        wr_acc     = wr && (qcount_q < QS_CNT);
        rd         = query && (qcount_q != 8'd0);
        prev_ptr_d = pWR;
        rd_ptr_d   = rd_ptr_q;
        out_d      = out_q;
        qcount_d   = qcount_q;
        if (rd) begin
            out_d    = mem[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({wr_acc, rd})
            2'b10:   qcount_d = qcount_q + 8'd1;
            2'b01:   qcount_d = qcount_q - 8'd1;
            default: qcount_d = qcount_q;
        endcase
        // Raised one cycle early, because a write seen now only lands in the
        // queue at the next edge.
        full = (qcount_q == QS_CNT) || ((qcount_q == QS_CNT - 8'd1) && wr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_ptr_q <= '1;
            rd_ptr_q   <= '0;
            qcount_q   <= 8'd0;
            out_q      <= 8'h00;
        end else begin
            prev_ptr_q <= prev_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            qcount_q   <= qcount_d;
            out_q      <= out_d;
        end
    end

    // Storage is not reset; its contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem[pWR] <= in_data;
        end
    end

    assign out_queue = out_q;
    assign qcount    = qcount_q;

endmodule

// File: tb/tb_queue.sv
module tb_queue;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] pWR;
    logic [7:0] in_data;
    logic       query;
    logic [7:0] out_queue;
    logic [7:0] qcount;
    logic       full;

    int checks = 0;
    int errors = 0;

    queue #(.QS(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .pWR       (pWR),
        .in_data   (in_data),
        .query     (query),
        .out_queue (out_queue),
        .qcount    (qcount),
        .full      (full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [2:0] p, input logic [7:0] d, input logic q);
        rst     = r;
        pWR     = p;
        in_data = d;
        query   = q;
    endtask

    // Advance one rising edge and return at the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [2:0] wptr;
        logic [2:0] pprev;
        logic [7:0] nd;
        logic [7:0] exp_rd;
        int         cnt;
        int         cyc;
        logic       do_wr;
        logic       do_q;

        drive(1'b1, 3'd7, 8'h00, 1'b0);
        @(negedge clk);
        tick();
        tick();

        // Reset state with pWR idling at QS-1.
        drive(1'b0, 3'd7, 8'h00, 1'b0);
        #1;
        chk("rst_full", {7'b0, full}, 8'h00);
        tick();
        chk("rst_qcount", qcount, 8'd0);
        chk("rst_out", out_queue, 8'h00);
        chk("rst_full_idle", {7'b0, full}, 8'h00);

        // Two writes, then a single read pulse.
        drive(1'b0, 3'd0, 8'h00, 1'b0); tick();
        drive(1'b0, 3'd1, 8'h01, 1'b0); tick();
        chk("two_wr_qcount", qcount, 8'd2);
        drive(1'b0, 3'd1, 8'h55, 1'b1); tick();
        chk("pop1_out", out_queue, 8'h00);
        chk("pop1_qcount", qcount, 8'd1);
        drive(1'b0, 3'd1, 8'h55, 1'b0); tick();
        chk("hold_out", out_queue, 8'h00);
        chk("hold_qcount", qcount, 8'd1);

        // Streaming: write 0..31 while the queue has room, pop every 3rd cycle.
        drive(1'b1, 3'd7, 8'h00, 1'b0); tick();
        drive(1'b0, 3'd7, 8'h00, 1'b0);
        wptr = 3'd0; pprev = 3'd7; nd = 8'd0; exp_rd = 8'd0; cnt = 0; cyc = 0;
        while (exp_rd < 8'd32 && cyc < 400) begin
            do_wr = (nd < 8'd32) && (cnt < 8);
            do_q  = (cyc % 3 == 2);
            drive(1'b0, do_wr ? wptr : pprev, nd, do_q);
            #1;
            chk("stream_full", {7'b0, full}, {7'b0, (cnt == 8) || (cnt == 7 && do_wr)});
            tick();
            if (do_q && cnt > 0) begin
                chk("stream_data", out_queue, exp_rd);
                exp_rd++;
                cnt--;
            end
            if (do_wr) begin
                cnt++;
                pprev = wptr;
                wptr  = wptr + 3'd1;
                nd++;
            end
            chk("stream_qcount", qcount, 8'(cnt));
            chk("stream_le8", {7'b0, qcount <= 8'd8}, 8'h01);
            cyc++;
        end
        chk("stream_done", exp_rd, 8'd32);

        // Fill with A0..A7 (queue is empty, prev pointer is 7).
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 3'(i), 8'hA0 + 8'(i), 1'b0);
            #1;
            chk("fill_full_early", {7'b0, full}, (i == 7) ? 8'h01 : 8'h00);
            tick();
        end
        chk("fill_qcount", qcount, 8'd8);
        chk("fill_full", {7'b0, full}, 8'h01);

        // Extra write while full is dropped.
        drive(1'b0, 3'd0, 8'hFF, 1'b0); tick();
        chk("ovf_qcount", qcount, 8'd8);

        // Write and read together while full: read happens, write dropped.
        drive(1'b0, 3'd1, 8'hEE, 1'b1); tick();
        chk("full_rw_out", out_queue, 8'hA0);
        chk("full_rw_qcount", qcount, 8'd7);
        for (int i = 1; i < 8; i++) begin
            drive(1'b0, 3'd1, 8'hEE, 1'b1); tick();
            chk("drain_out", out_queue, 8'hA0 + 8'(i));
        end
        chk("drain_qcount", qcount, 8'd0);

        // Pop on empty is ignored.
        drive(1'b0, 3'd1, 8'hEE, 1'b1); tick();
        chk("empty_out", out_queue, 8'hA7);
        chk("empty_qcount", qcount, 8'd0);

        // Fresh start: simultaneous write and pop at qcount=3, then reset mid-stream.
        drive(1'b1, 3'd7, 8'h00, 1'b0); tick();
        chk("rst2_out", out_queue, 8'h00);
        drive(1'b0, 3'd0, 8'h10, 1'b0); tick();
        drive(1'b0, 3'd1, 8'h11, 1'b0); tick();
        drive(1'b0, 3'd2, 8'h12, 1'b0); tick();
        chk("three_qcount", qcount, 8'd3);
        drive(1'b0, 3'd3, 8'h13, 1'b1); tick();
        chk("rw_qcount", qcount, 8'd3);
        chk("rw_out", out_queue, 8'h10);
        drive(1'b0, 3'd4, 8'h14, 1'b0); tick();
        chk("rw_after_qcount", qcount, 8'd4);
        drive(1'b1, 3'd7, 8'h15, 1'b1); tick();
        chk("midrst_qcount", qcount, 8'd0);
        chk("midrst_out", out_queue, 8'h00);
        drive(1'b0, 3'd7, 8'h00, 1'b0);
        #1;
        chk("midrst_full", {7'b0, full}, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/queue.md
Name: queue

Overview:
- Byte-wide circular FIFO of QS entries with a pointer-driven write port and a pulse-driven read port.
- The producer does not use a write-enable. It presents a new write address (pWR, incremented modulo QS) together with the data, and the queue detects each pointer change as one write.
- The consumer pulses query to pop the oldest byte onto out_queue.
- qcount and full provide flow control between a streaming producer and a slower consumer.

Parameters:
- QS, 8: queue depth in bytes. Power of two, 2..128. Pointer width PW = $clog2(QS).

Ports:
- clk, input, 1: rising-edge clock; the only clock.
- rst, input, 1: synchronous reset, active-high.
- pWR, input, PW: producer write address. A change relative to the previously sampled value is one write.
- in_data, input, 8: write data, sampled together with pWR.
- query, input, 1: read request, sampled each rising edge.
- out_queue, output, 8: registered read data.
- qcount, output, 8: number of stored entries, 0..QS, registered.
- full, output, 1: combinational flow-control flag; the producer must not issue a new write while it is high.

Behaviour:
- Internal state:
  - mem[QS] x 8 storage.
  - prev_ptr (PW bits): last sampled pWR.
  - rd_ptr (PW bits): read address.
  - qcount.
  - out_queue register.
- Reset (rst high at a rising edge):
  - qcount=0, rd_ptr=0, out_queue=8'h00, prev_ptr=QS-1 (all ones). mem contents are don't-care.
  - Writes and reads are ignored while rst is high.
  - Producer contract: pWR idles at QS-1 out of reset, so the first write uses address 0.
- Write detect: wr = (pWR != prev_ptr). prev_ptr <= pWR every non-reset edge.
- Write accept: if wr and qcount < QS, then mem[pWR] <= in_data.
  - If wr and qcount == QS, the write is dropped (protocol violation); prev_ptr still updates.
- Producer contract: pWR advances by exactly 1 (mod QS) per write, wrapping QS-1 -> 0. The storage address is pWR itself.
- Read: if query high and qcount > 0, then out_queue <= mem[rd_ptr] and rd_ptr <= rd_ptr+1 (mod QS).
  - Latency: data is valid on out_queue one cycle after the edge where query is sampled high.
  - out_queue holds its value until the next successful read.
- Read with query high and qcount == 0 is ignored: out_queue holds, nothing changes.
- query is level-sampled: every edge with query high pops one entry. A single-cycle pulse pops exactly one.
- qcount update per edge:
  - +1 on an accepted write only.
  - -1 on a successful read only.
  - Unchanged when both happen on the same edge, or when neither happens.
- Simultaneous write and read when qcount == QS: the read is performed; the write is dropped (write is evaluated before the read frees the slot).
- full = (qcount == QS) or (qcount == QS-1 and wr). This asserts one cycle early so that a producer acting on full at edge t cannot overflow, given the one-cycle write pipeline. full is 0 after reset.
- Order: strictly FIFO across wrap-around of both pointers.

Test Plan:
- Reset, then hold pWR=QS-1 with no query -> qcount=0, full=0, out_queue=0.
- Write 8'h00 at pWR=0 and 8'h01 at pWR=1 on consecutive cycles -> qcount reaches 2. Pulse query once -> out_queue=8'h00 next cycle, qcount=1.
- Stream data 0..31 with pWR=0,1,..7,0,.. (writing each cycle while full is low) and pop one entry every 3 cycles:
  - every popped value equals the next expected byte 0,1,2,...,31;
  - qcount never exceeds 8;
  - full is asserted whenever qcount==8, or qcount==7 with a write pending.
- Fill to qcount=8 with 8'hA0..8'hA7, then attempt an extra write -> qcount stays 8; the next 8 pops return A0..A7 in order.
- Pop on empty: query high with qcount=0 -> out_queue unchanged, qcount stays 0.
- Write and pop on the same edge with qcount=3 -> qcount stays 3, out_queue = oldest entry. Asserting rst mid-stream -> qcount=0 and out_queue=0 on the next cycle.
